// File: rtl/alu_stream_if.sv
// Command/result handshake bundle between the command sequencer, the ALU and writeback.
interface alu_stream_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned RW = 2 * N + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  opa;
  logic [N-1:0]  opb;
  logic          cin;
  logic          mode;
  logic [3:0]    cmd;
  logic [1:0]    inp_valid;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] res;
  logic          cout;
  logic          oflow;
  logic          g;
  logic          l;
  logic          e;
  logic          err;

  // Sequencer/writeback side
  modport master (
    output in_valid, opa, opb, cin, mode, cmd, inp_valid, out_ready,
    input  in_ready, out_valid, res, cout, oflow, g, l, e, err
  );

  // ALU side
  modport slave (
    input  in_valid, opa, opb, cin, mode, cmd, inp_valid, out_ready,
    output in_ready, out_valid, res, cout, oflow, g, l, e, err
  );
endinterface

// File: rtl/alu_stream.sv
// Handshaked ALU: one command per transfer, single-cycle ops or MUL_LAT-cycle multiplies,
// result and flags held until the sink takes them.
module alu_stream #(
  parameter int unsigned N       = 8,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_stream_if.slave  bus
);
  localparam int unsigned RW = 2 * N + 1;
  localparam int unsigned N1 = N + 1;
  localparam int unsigned CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  // Arithmetic command codes
  localparam logic [3:0] A_ADD  = 4'd0,  A_SUB  = 4'd1,  A_ADDC = 4'd2,  A_SUBB = 4'd3;
  localparam logic [3:0] A_INCA = 4'd4,  A_DECA = 4'd5,  A_INCB = 4'd6,  A_DECB = 4'd7;
  localparam logic [3:0] A_CMP  = 4'd8,  A_MULI = 4'd9,  A_MULS = 4'd10, A_SADD = 4'd11;
  localparam logic [3:0] A_SSUB = 4'd12;
  // Logic command codes
  localparam logic [3:0] L_AND  = 4'd0,  L_NAND = 4'd1,  L_OR   = 4'd2,  L_NOR  = 4'd3;
  localparam logic [3:0] L_XOR  = 4'd4,  L_XNOR = 4'd5,  L_NOTA = 4'd6,  L_NOTB = 4'd7;
  localparam logic [3:0] L_SHRA = 4'd8,  L_SHLA = 4'd9,  L_SHRB = 4'd10, L_SHLB = 4'd11;
  localparam logic [3:0] L_ROL  = 4'd12, L_ROR  = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          cout;
    logic          oflow;
    logic          g;
    logic          l;
    logic          e;
    logic          err;
  } result_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] prod_q, prod_d;
  result_t       rslt_q, rslt_d;

  logic          accept;
  result_t       alu_c;
  logic          alu_mul_c;
  logic [RW-1:0] prod_c;
  logic [N:0]    nres_c;
  logic [1:0]    need_c;
  logic          known_c;
  logic          rot_err_c;

  logic [N-1:0]  a, b;
  logic [N:0]    sum_ab, sum_abc, b_cin, ssum, sdiff, a_p1, b_p1;
  logic [N-1:0]  rol_a, ror_a;

  assign a       = bus.opa;
  assign b       = bus.opb;
  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign sum_abc = sum_ab + N1'(bus.cin);
  assign b_cin   = {1'b0, b} + N1'(bus.cin);
  assign ssum    = {a[N-1], a} + {b[N-1], b};
  assign sdiff   = {a[N-1], a} - {b[N-1], b};
  assign a_p1    = {1'b0, a} + N1'(1);
  assign b_p1    = {1'b0, b} + N1'(1);
  // A shift by N (b == 0) yields zero, so the OR reduces to A itself
  assign rol_a   = (a << b) | (a >> (N'(N) - b));
  assign ror_a   = (a >> b) | (a << (N'(N) - b));

  assign bus.in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_HOLD) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.res       = rslt_q.res;
  assign bus.cout      = rslt_q.cout;
  assign bus.oflow     = rslt_q.oflow;
  assign bus.g         = rslt_q.g;
  assign bus.l         = rslt_q.l;
  assign bus.e         = rslt_q.e;
  assign bus.err       = rslt_q.err;

  // Decode the presented command into a result, or a product for the multiply path
  always_comb begin
    alu_c     = '0;
    alu_mul_c = 1'b0;
    prod_c    = '0;
    nres_c    = '0;
    need_c    = 2'b11;
    known_c   = 1'b1;
    rot_err_c = 1'b0;
    if (bus.mode) begin
      case (bus.cmd)
        A_ADD:  begin nres_c = sum_ab;  alu_c.cout = sum_ab[N]; end
        A_SUB:  begin nres_c = {1'b0, a - b}; alu_c.oflow = (a < b); end
        A_ADDC: begin nres_c = sum_abc; alu_c.cout = sum_abc[N]; end
        A_SUBB: begin
          nres_c      = {1'b0, a - b - N'(bus.cin)};
          alu_c.oflow = ({1'b0, a} < b_cin);
        end
        A_INCA: begin need_c = 2'b10; nres_c = {1'b0, a + N'(1)}; alu_c.cout  = &a; end
        A_DECA: begin need_c = 2'b10; nres_c = {1'b0, a - N'(1)}; alu_c.oflow = ~|a; end
        A_INCB: begin need_c = 2'b01; nres_c = {1'b0, b + N'(1)}; alu_c.cout  = &b; end
        A_DECB: begin need_c = 2'b01; nres_c = {1'b0, b - N'(1)}; alu_c.oflow = ~|b; end
        A_CMP:  begin alu_c.g = (a > b); alu_c.l = (a < b); alu_c.e = (a == b); end
        A_MULI: begin alu_mul_c = 1'b1; prod_c = RW'(a_p1) * RW'(b_p1); end
        A_MULS: begin alu_mul_c = 1'b1; prod_c = RW'({a[N-2:0], 1'b0}) * RW'(b); end
        A_SADD, A_SSUB: begin
          nres_c      = (bus.cmd == A_SADD) ? ssum : sdiff;
          alu_c.oflow = nres_c[N] ^ nres_c[N-1];
          alu_c.g     = ($signed(a) > $signed(b));
          alu_c.l     = ($signed(a) < $signed(b));
          alu_c.e     = (a == b);
        end
        default: known_c = 1'b0;
      endcase
    end else begin
      case (bus.cmd)
        L_AND:  nres_c = {1'b0, a & b};
        L_NAND: nres_c = {1'b0, ~(a & b)};
        L_OR:   nres_c = {1'b0, a | b};
        L_NOR:  nres_c = {1'b0, ~(a | b)};
        L_XOR:  nres_c = {1'b0, a ^ b};
        L_XNOR: nres_c = {1'b0, ~(a ^ b)};
        L_NOTA: begin need_c = 2'b10; nres_c = {1'b0, ~a}; end
        L_NOTB: begin need_c = 2'b01; nres_c = {1'b0, ~b}; end
        L_SHRA: begin need_c = 2'b10; nres_c = {2'b00, a[N-1:1]}; end
        L_SHLA: begin need_c = 2'b10; nres_c = {a, 1'b0}; end
        L_SHRB: begin need_c = 2'b01; nres_c = {2'b00, b[N-1:1]}; end
        L_SHLB: begin need_c = 2'b01; nres_c = {b, 1'b0}; end
        L_ROL:  begin nres_c = {1'b0, rol_a}; rot_err_c = (b >= N'(N)); end
        L_ROR:  begin nres_c = {1'b0, ror_a}; rot_err_c = (b >= N'(N)); end
        default: known_c = 1'b0;
      endcase
    end
    if (!known_c || rot_err_c || ((need_c & ~bus.inp_valid) != 2'b00)) begin
      alu_c     = '0;
      alu_c.err = 1'b1;
      alu_mul_c = 1'b0;
    end else begin
      alu_c.res = RW'(nres_c);
    end
  end

  // Next-state: multiply countdown, result hand-off, and back-to-back accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rslt_d  = rslt_q;
    case (state_q)
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = S_HOLD;
          rslt_d     = '0;
          rslt_d.res = prod_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: if (bus.out_ready) state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      if (alu_mul_c) begin
        state_d = S_MUL;
        cnt_d   = CW'(1);
        prod_d  = prod_c;
      end else begin
        state_d = S_HOLD;
        rslt_d  = alu_c;
      end
    end
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      rslt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rslt_q  <= rslt_d;
    end
  end
endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream: directed scenarios plus randomized traffic against a reference model.
module tb_alu_stream;
  localparam int unsigned N       = 8;
  localparam int unsigned MUL_LAT = 3;

  typedef struct packed {
    logic [16:0] res;
    logic        cout;
    logic        oflow;
    logic        g;
    logic        l;
    logic        e;
    logic        err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] edge_vals [5] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h01};

  alu_stream_if #(.N(N)) bus ();

  alu_stream #(.N(N), .MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {bus.res, bus.cout, bus.oflow, bus.g, bus.l, bus.e, bus.err};
  endfunction

  // flags: {cout, oflow, g, l, e, err}
  function automatic obs_t mk(input logic [16:0] res, input logic [5:0] fl);
    return {res, fl};
  endfunction

  // Reference model: result from the command rules using integer arithmetic
  function automatic obs_t model(input logic mode, input logic [3:0] cmd,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic [1:0] iv, output int lat);
    int ia, ib, sa, sb, r, need, v;
    bit bad;
    obs_t o;
    ia = int'(a); ib = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    o = '0; lat = 1; need = 3; bad = 0; r = 0;
    if (mode) begin
      case (cmd)
        0: begin r = ia + ib; o.cout = (r > 255); end
        1: begin r = (ia - ib) & 255; o.oflow = (ia < ib); end
        2: begin r = ia + ib + int'(cin); o.cout = (r > 255); end
        3: begin r = (ia - ib - int'(cin)) & 255; o.oflow = (ia < ib + int'(cin)); end
        4: begin need = 2; r = (ia + 1) % 256; o.cout = (ia == 255); end
        5: begin need = 2; r = (ia + 255) % 256; o.oflow = (ia == 0); end
        6: begin need = 1; r = (ib + 1) % 256; o.cout = (ib == 255); end
        7: begin need = 1; r = (ib + 255) % 256; o.oflow = (ib == 0); end
        8: begin o.g = (ia > ib); o.l = (ia < ib); o.e = (ia == ib); end
        9: begin r = (ia + 1) * (ib + 1); lat = MUL_LAT; end
        10: begin r = ((2 * ia) % 256) * ib; lat = MUL_LAT; end
        11, 12: begin
          v = (cmd == 11) ? sa + sb : sa - sb;
          r = v & 511;
          o.oflow = (v > 127) || (v < -128);
          o.g = (sa > sb); o.l = (sa < sb); o.e = (sa == sb);
        end
        default: bad = 1;
      endcase
    end else begin
      case (cmd)
        0: r = ia & ib;
        1: r = 255 - (ia & ib);
        2: r = ia | ib;
        3: r = 255 - (ia | ib);
        4: r = ia ^ ib;
        5: r = 255 - (ia ^ ib);
        6: begin need = 2; r = 255 - ia; end
        7: begin need = 1; r = 255 - ib; end
        8: begin need = 2; r = ia / 2; end
        9: begin need = 2; r = ia * 2; end
        10: begin need = 1; r = ib / 2; end
        11: begin need = 1; r = ib * 2; end
        12, 13: begin
          if (ib >= 8) bad = 1;
          else begin
            v = ia;
            for (int k = 0; k < ib; k++)
              v = (cmd == 12) ? (((v * 2) | (v / 128)) & 255) : ((v / 2) | ((v % 2) * 128));
            r = v;
          end
        end
        default: bad = 1;
      endcase
    end
    if (bad || ((need & ~int'(iv)) != 0)) begin
      o = '0; o.err = 1'b1; lat = 1;
    end else begin
      o.res = 17'(r);
    end
    return o;
  endfunction

  task automatic set_cmd(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [1:0] iv);
    bus.mode = mode; bus.cmd = cmd; bus.opa = a; bus.opb = b;
    bus.cin = cin; bus.inp_valid = iv;
  endtask

  // Issue one command from idle/hold with the sink ready; return the result and its latency
  task automatic do_op(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input logic [1:0] iv,
                       output obs_t o, output int lat);
    set_cmd(mode, cmd, a, b, cin, iv);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.out_valid) begin lat = k; break; end
      @(negedge clk);
    end
    o = observe();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_cmd(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++;
      if (observe() !== obs_t'(0)) begin errors++; $display("FAIL reset_result: got %h want 0", observe()); end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp;
    set_cmd(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    exp = mk(17'h100, 6'b100000);
    checks++;
    if (bus.out_valid !== 1'b1 || observe() !== exp) begin
      errors++; $display("FAIL add_result: got valid=%b %h want 1 %h", bus.out_valid, observe(), exp);
    end
    set_cmd(1'b1, 4'd1, 8'h05, 8'h07, 1'b0, 2'b11);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp = mk(17'h0FE, 6'b010000);
    checks++;
    if (bus.out_valid !== 1'b1 || observe() !== exp) begin
      errors++; $display("FAIL sub_result: got valid=%b %h want 1 %h", bus.out_valid, observe(), exp);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_mul();
    obs_t exp;
    int lat;
    set_cmd(1'b1, 4'd9, 8'hFF, 8'hFF, 1'b0, 2'b11);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.out_valid) begin lat = k; break; end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready: got %b want 0 at cycle %0d", bus.in_ready, k); end
      @(negedge clk);
    end
    checks++;
    if (lat != MUL_LAT) begin errors++; $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT); end
    exp = mk(17'h10000, 6'b000000);
    checks++;
    if (observe() !== exp) begin errors++; $display("FAIL muli_result: got %h want %h", observe(), exp); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    obs_t exp;
    set_cmd(1'b1, 4'd11, 8'h7F, 8'h01, 1'b0, 2'b11);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    set_cmd(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11);
    exp = mk(17'h080, 6'b011000);
    repeat (4) begin
      checks++;
      if (bus.out_valid !== 1'b1 || observe() !== exp) begin
        errors++; $display("FAIL stall_result: got valid=%b %h want 1 %h", bus.out_valid, observe(), exp);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_errors();
    obs_t o;
    int lat;
    do_op(1'b0, 4'd12, 8'h81, 8'h08, 1'b0, 2'b11, o, lat);
    checks++;
    if (o !== mk(17'h0, 6'b000001) || lat != 1) begin errors++; $display("FAIL rol_range: got %h lat %0d want err lat 1", o, lat); end
    do_op(1'b1, 4'd4, 8'h10, 8'h20, 1'b0, 2'b01, o, lat);
    checks++;
    if (o !== mk(17'h0, 6'b000001) || lat != 1) begin errors++; $display("FAIL inca_missing: got %h lat %0d want err lat 1", o, lat); end
    do_op(1'b0, 4'd13, 8'h81, 8'h01, 1'b0, 2'b11, o, lat);
    checks++;
    if (o !== mk(17'h0C0, 6'b000000) || lat != 1) begin errors++; $display("FAIL ror_result: got %h lat %0d want 0c0 lat 1", o, lat); end
    do_op(1'b1, 4'd15, 8'h33, 8'h44, 1'b1, 2'b11, o, lat);
    checks++;
    if (o !== mk(17'h0, 6'b000001) || lat != 1) begin errors++; $display("FAIL undef_cmd: got %h lat %0d want err lat 1", o, lat); end
    do_op(1'b1, 4'd10, 8'h12, 8'h34, 1'b0, 2'b10, o, lat);
    checks++;
    if (o !== mk(17'h0, 6'b000001) || lat != 1) begin errors++; $display("FAIL muls_missing: got %h lat %0d want err lat 1", o, lat); end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    obs_t o;
    int lat;
    set_cmd(1'b1, 4'd10, 8'h03, 8'h05, 1'b0, 2'b11);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_early_valid: got %b want 0", bus.out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || observe() !== obs_t'(0)) begin
      errors++; $display("FAIL abort_reset: got valid=%b ready=%b %h want 0 0 0", bus.out_valid, bus.in_ready, observe());
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b want 0", bus.out_valid); end
    end
    do_op(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11, o, lat);
    checks++;
    if (o !== mk(17'h002, 6'b000000) || lat != 1) begin errors++; $display("FAIL post_abort_add: got %h lat %0d want 002 lat 1", o, lat); end
  endtask

  task automatic test_random();
    bit   busy, ev, er;
    int   acc, cyc, lat, elat;
    obs_t exp;
    logic [7:0] ra, rb;
    busy = 0; acc = 0; cyc = 0; lat = 1; exp = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      ev = busy && (cyc >= acc + lat - 1);
      checks++;
      if (bus.out_valid !== ev) begin errors++; $display("FAIL rand_out_valid: cycle %0d got %b want %b", cyc, bus.out_valid, ev); end
      if (ev) begin
        checks++;
        if (observe() !== exp) begin errors++; $display("FAIL rand_result: cycle %0d got %h want %h", cyc, observe(), exp); end
      end
      ra = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(4)] : 8'($urandom);
      rb = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(4)] : 8'($urandom);
      bus.mode = 1'($urandom_range(1));
      bus.cmd  = 4'($urandom_range(15));
      if (!bus.mode && bus.cmd >= 4'd12 && $urandom_range(1) == 1) rb = 8'($urandom_range(9));
      set_cmd(bus.mode, bus.cmd, ra, rb, 1'($urandom_range(1)),
              ($urandom_range(5) == 0) ? 2'($urandom_range(3)) : 2'b11);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.in_valid  = ($urandom_range(1) != 0);
      #1;
      er = !busy || (ev && bus.out_ready);
      checks++;
      if (bus.in_ready !== er) begin errors++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", cyc, bus.in_ready, er); end
      if (ev && bus.out_ready) busy = 0;
      if (bus.in_valid && er) begin
        busy = 1;
        acc  = cyc + 1;
        exp  = model(bus.mode, bus.cmd, bus.opa, bus.opb, bus.cin, bus.inp_valid, elat);
        lat  = elat;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_cmd(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
    test_reset();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_errors();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
